// File: rtl/dist_pkg.sv
// dist_pkg: mode encoding, per-beat config and range helpers for distortion_pipe.
// DIST_SOFTCLIP_EN (used by dist_shaper) turns mode 4 into a soft knee.
package dist_pkg;
    localparam int DIST_DATA_W = 16;
    localparam int DIST_GAIN_W = 12;

    typedef enum logic [2:0] {
        MODE_BYPASS    = 3'd0,
        MODE_HARD      = 3'd1,
        MODE_HALF_RECT = 3'd2,
        MODE_FULL_RECT = 3'd3,
        MODE_SOFT      = 3'd4
    } dist_mode_t;

    typedef struct packed {
        dist_mode_t             mode;
        logic [DIST_GAIN_W-1:0] gain;
        logic [DIST_DATA_W-1:0] thresh;
    } dist_cfg_t;

    function automatic int DIST_MAX(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int DIST_MIN(input int w);
        return -(1 << (w - 1));
    endfunction
endpackage

// File: rtl/dist_shaper.sv
// dist_shaper: combinational waveshaping and symmetric saturation for one channel.
// With DIST_SOFTCLIP_EN mode 4 applies a soft knee at T/2; without it mode 4 is HARD.
module dist_shaper
    import dist_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PW     = 29
) (
    input  logic [2:0]           mode_i,
    input  logic [DATA_W-1:0]    thresh_i,
    input  logic [DATA_W-1:0]    x_i,
    input  logic signed [PW-1:0] v_i,
    output logic [DATA_W-1:0]    y_o,
    output logic                 clip_o
);
    localparam logic signed [PW-1:0] MAX = PW'(DIST_MAX(DATA_W));

    logic signed [PW-1:0] t, a, hc, sa, r;
    logic byp, hard, half, full;
`ifdef DIST_SOFTCLIP_EN
    logic signed [PW-1:0] h, k, kc;
    logic knee;
    assign knee = mode_i == MODE_SOFT;
    assign hard = mode_i == MODE_HARD;
`else
    assign hard = mode_i == MODE_HARD || mode_i == MODE_SOFT;
`endif
    assign half = mode_i == MODE_HALF_RECT;
    assign full = mode_i == MODE_FULL_RECT;
    assign byp  = mode_i == MODE_BYPASS || mode_i > MODE_SOFT;

    always_comb begin
        // any threshold with the top bit set exceeds the positive full scale
        t  = thresh_i[DATA_W-1] ? MAX : $signed({{(PW-DATA_W){1'b0}}, thresh_i});
        a  = v_i[PW-1] ? -v_i : v_i;
        hc = (v_i > t) ? t : (v_i < -t) ? -t : v_i;
        sa = (a > MAX) ? MAX : a;
        r  = hard ? hc : half ? (v_i[PW-1] ? '0 : ((v_i > MAX) ? MAX : v_i)) : sa;
`ifdef DIST_SOFTCLIP_EN
        h  = t >>> 1;
        k  = (a <= h) ? a : h + ((a - h) >>> 2);
        kc = (k > t) ? t : k;
        r  = knee ? (v_i[PW-1] ? -kc : kc) : r;
`endif
    end

    assign y_o    = byp ? x_i : r[DATA_W-1:0];
    assign clip_o = !byp && ((half || full) ? ((half ? v_i : a) > MAX) : (r != v_i));
endmodule

// File: rtl/distortion_pipe.sv
// distortion_pipe: 3-stage gain -> waveshape -> saturate stage with valid/ready on both sides.
// Define DIST_SOFTCLIP_EN to give mode 4 a soft knee; otherwise mode 4 behaves as HARD.
module distortion_pipe
    import dist_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_CH    = 2,
    parameter int GAIN_W    = 12,
    parameter int FRAC_BITS = 6,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic [2:0]               cfg_mode,
    input  logic [GAIN_W-1:0]        cfg_gain,
    input  logic [DATA_W-1:0]        cfg_thresh,
    input  logic                     clip_clr,
    output logic [CNT_W-1:0]         clip_cnt
);
    localparam int PW = DATA_W + GAIN_W + 1;

    logic                     adv, v1_q, v2_q, out_valid_q, clip3_q, clip_d;
    logic [NUM_CH*DATA_W-1:0] x1_q, x2_q, out_data_q, y_d;
    logic [NUM_CH*PW-1:0]     p_d, p2_q;
    logic [NUM_CH-1:0]        clip_ch;
    logic [GAIN_W-1:0]        gain1;
    logic [2:0]               mode2_q;
    logic [DATA_W-1:0]        thresh2_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    dist_cfg_t                cfg1_q;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign clip_cnt  = cnt_q;
    assign gain1     = GAIN_W'(cfg1_q.gain);
    assign clip_d    = |clip_ch;
    // a clear in the same cycle as a counted beat wins
    assign cnt_d = clip_clr ? '0 :
                   (out_valid_q && out_ready && clip3_q && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [PW-1:0] xe, ge, pr;
        assign xe = {{(GAIN_W+1){x1_q[c*DATA_W+DATA_W-1]}}, x1_q[c*DATA_W +: DATA_W]};
        assign ge = {{(DATA_W+1){1'b0}}, gain1};
        assign pr = xe * ge;
        assign p_d[c*PW +: PW] = pr >>> FRAC_BITS;

        dist_shaper #(.DATA_W(DATA_W), .PW(PW)) u_shaper (
            .mode_i  (mode2_q),
            .thresh_i(thresh2_q),
            .x_i     (x2_q[c*DATA_W +: DATA_W]),
            .v_i     ($signed(p2_q[c*PW +: PW])),
            .y_o     (y_d[c*DATA_W +: DATA_W]),
            .clip_o  (clip_ch[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            clip3_q     <= 1'b0;
            x1_q        <= '0;
            x2_q        <= '0;
            out_data_q  <= '0;
            p2_q        <= '0;
            cfg1_q      <= '0;
            mode2_q     <= '0;
            thresh2_q   <= '0;
        end else if (adv) begin
            v1_q        <= in_valid;
            x1_q        <= in_data;
            cfg1_q      <= '{mode: dist_mode_t'(cfg_mode), gain: DIST_GAIN_W'(cfg_gain),
                             thresh: DIST_DATA_W'(cfg_thresh)};
            v2_q        <= v1_q;
            x2_q        <= x1_q;
            p2_q        <= p_d;
            mode2_q     <= cfg1_q.mode;
            thresh2_q   <= DATA_W'(cfg1_q.thresh);
            out_valid_q <= v2_q;
            out_data_q  <= y_d;
            clip3_q     <= v2_q && clip_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_distortion_pipe.sv
// tb_distortion_pipe: directed vectors plus a per-cycle scoreboard built from the arithmetic rules.
module tb_distortion_pipe;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef DIST_SOFTCLIP_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1, clip_clr = 0;
    logic        in_ready, out_valid;
    logic [31:0] in_data = '0, out_data;
    logic [2:0]  cfg_mode = '0;
    logic [11:0] cfg_gain = '0;
    logic [15:0] cfg_thresh = '0;
    logic [CW-1:0] clip_cnt;

    distortion_pipe #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .cfg_mode(cfg_mode),
        .cfg_gain(cfg_gain), .cfg_thresh(cfg_thresh), .clip_clr(clip_clr), .clip_cnt(clip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; bit clip; } exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, cnt_m = 0, npop = 0;
    bit stalled_prev = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model(input int m, input int x, input int g, input int th,
                                  output int y, output bit cl);
        longint p, v, t, a, h, k;
        t = th > 32767 ? 32767 : th;
        p = longint'(x) * g;
        v = p >= 0 ? p / 64 : -((-p + 63) / 64);
        a = v < 0 ? -v : v;
        y = x;
        cl = 0;
        if (m == 1 || (m == 4 && !SOFT)) begin
            y = int'(v > t ? t : (v < -t ? -t : v));
            cl = (y != v);
        end else if (m == 2) begin
            y = v < 0 ? 0 : int'(v > 32767 ? 32767 : v);
            cl = v > 32767;
        end else if (m == 3) begin
            y = int'(a > 32767 ? 32767 : a);
            cl = a > 32767;
        end else if (m == 4) begin
            h = t / 2;
            k = a <= h ? a : h + (a - h) / 4;
            if (k > t) k = t;
            y = int'(v < 0 ? -k : k);
            cl = (y != v);
        end
    endfunction

    function automatic int ch(input int c);
        return int'($signed(out_data[c*16 +: 16]));
    endfunction

    // scoreboard: sampled 1 time unit before each rising edge
    always @(negedge clk) begin
        exp_t e;
        int y;
        bit cl;
        #4;
        if (rst) begin
            q.delete();
            cnt_m = 0;
            stalled_prev = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_clip_cnt", clip_cnt, 0);
        end else begin
            chk("clip_cnt", clip_cnt, cnt_m);
            if (stalled_prev) chk("stall_hold", out_valid, 1);
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_beat", 1, 0);
                else begin
                    chk("sb_data", out_data, q[0].data);
                    if (out_ready) begin
                        if (q[0].clip && cnt_m < CMAX) cnt_m++;
                        void'(q.pop_front());
                        npop++;
                    end
                end
            end
            if (clip_clr) cnt_m = 0;
            stalled_prev = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                e.clip = 0;
                for (int c = 0; c < 2; c++) begin
                    model(cfg_mode, int'($signed(in_data[c*16 +: 16])), cfg_gain, cfg_thresh, y, cl);
                    e.data[c*16 +: 16] = 16'(y);
                    e.clip |= cl;
                end
                q.push_back(e);
            end
        end
    end

    task automatic send(input int m, input int g, input int th, input int x0, input int x1);
        bit acc = 0;
        cfg_mode = 3'(m);
        cfg_gain = 12'(g);
        cfg_thresh = 16'(th);
        in_data = {16'(x1), 16'(x0)};
        in_valid = 1;
        for (int i = 0; i < 50 && !acc; i++) begin
            #4;
            acc = in_ready;
            @(negedge clk);
        end
        in_valid = 0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic expect_out(input string nm, input int e0, input int e1, output int lat);
        bit got = 0;
        lat = -1;
        for (int i = 0; i < 50 && !got; i++) begin
            #4;
            if (out_valid && out_ready) begin
                got = 1;
                lat = i;
                chk({nm, ".ch0"}, ch(0), e0);
                chk({nm, ".ch1"}, ch(1), e1);
            end
            @(negedge clk);
        end
        if (!got) chk({nm, ".timeout"}, 0, 1);
    endtask

    initial begin
        int lat, y, sent, cyc, np0;
        bit cl, seen;
        model(1, 1000, 256, 3000, y, cl);   chk("pin_hard", y, 3000); chk("pin_hard_clip", cl, 1);
        model(3, -32768, 64, 0, y, cl);     chk("pin_full", y, 32767); chk("pin_full_clip", cl, 1);
        model(2, -5, 64, 0, y, cl);         chk("pin_half", y, 0);     chk("pin_half_clip", cl, 0);
        model(1, -1, 32, 32767, y, cl);     chk("pin_floor", y, -1);
        model(4, 6000, 64, 8000, y, cl);    chk("pin_soft", y, SOFT ? 4500 : 6000);

        repeat (2) @(negedge clk);
        #4;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_clip_cnt", clip_cnt, 0);
        @(negedge clk);
        rst = 0;
        #4;
        chk("in_ready_after_reset", in_ready, 1);
        @(negedge clk);

        send(0, 256, 0, -32768, 1234);
        expect_out("bypass", -32768, 1234, lat);
        chk("latency", lat, 2);
        send(6, 256, 0, -7, 9);
        expect_out("bypass_m6", -7, 9, lat);
        chk("bypass_cnt", clip_cnt, 0);

        send(1, 256, 3000, 1000, -1000);
        expect_out("hard_clip", 3000, -3000, lat);
        chk("hard_cnt1", clip_cnt, 1);
        send(1, 256, 3000, 500, 0);
        expect_out("hard_pass", 2000, 0, lat);
        chk("hard_cnt_noinc", clip_cnt, 1);

        send(1, 128, 40000, 20000, 0);
        expect_out("thresh_clamp", 32767, 0, lat);
        send(3, 64, 0, -32768, 5);
        expect_out("full_rect", 32767, 5, lat);
        send(2, 64, 0, -5, 7);
        expect_out("half_rect", 0, 7, lat);
        chk("cnt_3", clip_cnt, 3);
        send(1, 256, 3000, 1000, 0);
        expect_out("hard_again", 3000, 0, lat);
        chk("cnt_sat", clip_cnt, 3);
        send(1, 64, 0, 123, -4);
        expect_out("t_zero", 0, 0, lat);
        send(1, 32, 32767, -1, 1);
        expect_out("floor", -1, 0, lat);

        out_ready = 0;
        send(1, 256, 3000, 1000, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #4;
            seen = out_valid;
            @(negedge clk);
        end
        chk("clr_beat_seen", seen, 1);
        out_ready = 1;
        clip_clr = 1;
        @(negedge clk);
        clip_clr = 0;
        #4;
        chk("clr_wins", clip_cnt, 0);
        @(negedge clk);

        send(1, 64, 32767, 1000, -1000);
        send(1, 128, 32767, 1000, -1000);
        expect_out("gain_old", 1000, -1000, lat);
        expect_out("gain_new", 2000, -2000, lat);

        send(4, 64, 8000, 6000, 3000);
        expect_out("soft_knee", SOFT ? 4500 : 6000, 3000, lat);
        send(4, 64, 8000, 30000, -30000);
        expect_out("soft_clamp", 8000, -8000, lat);

        np0 = npop;
        sent = 0;
        cyc = 0;
        while ((sent < 10 || npop - np0 < 10) && cyc < 400) begin
            if (sent < 10) begin
                in_valid = 1'($urandom_range(0, 1));
                cfg_mode = 3'(sent % 5);
                cfg_gain = 12'(40 + sent * 23);
                cfg_thresh = 16'(9000);
                in_data = {16'(7000 - sent * 1700), 16'(sent * 3300 - 15000)};
            end else in_valid = 0;
            out_ready = 1'(cyc % 2);
            #4;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 0;
        out_ready = 1;
        chk("bp_sent", sent, 10);
        chk("bp_recv", npop - np0, 10);

        send(1, 256, 3000, 1000, 0);
        expect_out("pre_rst", 3000, 0, lat);
        chk("pre_rst_cnt_nonzero", clip_cnt != 0, 1);
        send(0, 64, 0, 1, 1);
        send(0, 64, 0, 2, 2);
        send(0, 64, 0, 3, 3);
        rst = 1;
        #4;
        chk("rst_flush_valid", out_valid, 0);
        chk("rst_flush_cnt", clip_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            #4;
            chk("post_rst_quiet", out_valid, 0);
            @(negedge clk);
        end
        chk("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
